// File: rtl/spi_apb_sequencer_if.sv
// APB3 bus between the sequencer (master) and the CoreSPI register port (slave).
interface spi_apb_sequencer_if;
  logic [6:0] M_PADDR;
  logic       M_PSEL;
  logic       M_PENABLE;
  logic       M_PWRITE;
  logic [7:0] M_PWDATA;
  logic [7:0] M_PRDATA;
  logic       M_PREADY;
  logic       M_PSLVERR;

  modport master (
    output M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA,
    input  M_PRDATA, M_PREADY, M_PSLVERR
  );

  modport slave (
    input  M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA,
    output M_PRDATA, M_PREADY, M_PSLVERR
  );
endinterface

// File: rtl/spi_apb_sequencer.sv
// spi_apb_sequencer: APB3 master owning the CoreSPI register port, shared
// round-robin between two byte-stream requesters. Each byte is pushed to TX,
// STATUS is polled until RX is non-empty, then RX is popped.
module spi_apb_sequencer #(
  parameter logic [6:0]  ADDR_CTRL1  = 7'h00,
  parameter logic [6:0]  ADDR_RXDATA = 7'h08,
  parameter logic [6:0]  ADDR_TXDATA = 7'h0C,
  parameter logic [6:0]  ADDR_STATUS = 7'h20,
  parameter logic [6:0]  ADDR_SSEL   = 7'h24,
  parameter logic [6:0]  ADDR_TXLAST = 7'h28,
  parameter logic [7:0]  CTRL1_INIT  = 8'h03,
  parameter int unsigned RXEMPTY_BIT = 2,
  parameter logic [15:0] POLL_LIMIT  = 16'hFFFF
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic [1:0]  req_valid,
  input  logic [5:0]  req_ssel,
  input  logic [15:0] req_len,
  input  logic [15:0] tx_data,
  output logic [1:0]  tx_ack,
  output logic [7:0]  rx_data,
  output logic [1:0]  rx_valid,
  output logic [1:0]  done,
  output logic [1:0]  err,
  spi_apb_sequencer_if.master apb
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SSEL, S_TX, S_POLL, S_RX, S_DESEL, S_DONE
  } state_t;

  // Every APB op walks GAP (bus idle) -> SETUP -> ACCESS; the GAP cycle keeps
  // PSEL low between consecutive ops.
  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

  // Per-requester views of the packed request buses.
  logic [1:0][2:0] ssel_a;
  logic [1:0][7:0] len_a;
  logic [1:0][7:0] txd_a;
  assign ssel_a = req_ssel;
  assign len_a  = req_len;
  assign txd_a  = tx_data;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic        gnt_q, gnt_d;      // requester currently being served
  logic        prio_q, prio_d;    // requester favoured when both ask
  logic [2:0]  ssel_q, ssel_d;
  logic [7:0]  cnt_q, cnt_d;      // bytes still to transfer
  logic [15:0] poll_q, poll_d;    // consecutive STATUS reads with RX empty
  logic        err_q, err_d;
  logic [7:0]  rxd_q, rxd_d;
  logic [1:0]  rxv_q, rxv_d;

  logic        op_st, xfer, slverr, g;
  logic [1:0]  gnt_oh;
  logic [15:0] poll_inc;

  assign op_st  = (state_q == S_INIT) || (state_q == S_SSEL) || (state_q == S_TX) ||
                  (state_q == S_POLL) || (state_q == S_RX)   || (state_q == S_DESEL);
  assign xfer   = op_st && (phase_q == PH_ACCESS) && apb.M_PREADY;
  assign slverr = xfer && apb.M_PSLVERR;
  assign gnt_oh = gnt_q ? 2'b10 : 2'b01;
  assign poll_inc = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
  assign g = (req_valid == 2'b11) ? prio_q : req_valid[1];

  // State and datapath registers; reset aborts any APB op in flight.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= S_INIT;
      phase_q <= PH_GAP;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      ssel_q  <= '0;
      cnt_q   <= '0;
      poll_q  <= '0;
      err_q   <= 1'b0;
      rxd_q   <= '0;
      rxv_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      ssel_q  <= ssel_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
    end
  end

  // Next-state: APB phase sequencing plus per-op completion decisions.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    ssel_d  = ssel_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    err_d   = err_q;
    rxd_d   = rxd_q;
    rxv_d   = '0;
    tx_ack  = '0;
    if (op_st) begin
      case (phase_q)
        PH_GAP:   phase_d = PH_SETUP;
        PH_SETUP: phase_d = PH_ACCESS;
        default:  if (apb.M_PREADY) phase_d = PH_GAP;
      endcase
    end
    case (state_q)
      S_INIT: if (xfer) state_d = S_IDLE;
      S_IDLE: begin
        if (|req_valid) begin
          gnt_d   = g;
          ssel_d  = ssel_a[g];
          cnt_d   = len_a[g];
          err_d   = (len_a[g] == 8'd0);
          state_d = (len_a[g] == 8'd0) ? S_DONE : S_SSEL;
          phase_d = PH_GAP;
        end
      end
      S_SSEL: if (xfer) begin
        if (slverr) begin err_d = 1'b1; state_d = S_DESEL; end
        else state_d = S_TX;
      end
      S_TX: if (xfer) begin
        if (slverr) begin err_d = 1'b1; state_d = S_DESEL; end
        else begin
          tx_ack  = gnt_oh;
          poll_d  = '0;
          state_d = S_POLL;
        end
      end
      S_POLL: if (xfer) begin
        if (slverr) begin err_d = 1'b1; state_d = S_DESEL; end
        else if (!apb.M_PRDATA[RXEMPTY_BIT]) state_d = S_RX;
        else begin
          poll_d = poll_inc;
          if (poll_inc >= POLL_LIMIT) begin err_d = 1'b1; state_d = S_DESEL; end
        end
      end
      S_RX: if (xfer) begin
        if (slverr) begin err_d = 1'b1; state_d = S_DESEL; end
        else begin
          rxv_d   = gnt_oh;
          rxd_d   = apb.M_PRDATA;
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? S_DESEL : S_TX;
        end
      end
      S_DESEL: if (xfer) begin
        err_d   = err_q | apb.M_PSLVERR;
        state_d = S_DONE;
      end
      S_DONE: begin
        prio_d  = ~gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // APB drive: address/data held constant by state while the op is open.
  always_comb begin
    apb.M_PSEL    = op_st && (phase_q != PH_GAP);
    apb.M_PENABLE = op_st && (phase_q == PH_ACCESS);
    apb.M_PADDR   = '0;
    apb.M_PWRITE  = 1'b0;
    apb.M_PWDATA  = '0;
    if (op_st && (phase_q != PH_GAP)) begin
      case (state_q)
        S_INIT: begin
          apb.M_PADDR = ADDR_CTRL1; apb.M_PWRITE = 1'b1; apb.M_PWDATA = CTRL1_INIT;
        end
        S_SSEL: begin
          apb.M_PADDR = ADDR_SSEL; apb.M_PWRITE = 1'b1; apb.M_PWDATA = 8'b1 << ssel_q;
        end
        S_TX: begin
          apb.M_PADDR  = (cnt_q == 8'd1) ? ADDR_TXLAST : ADDR_TXDATA;
          apb.M_PWRITE = 1'b1;
          apb.M_PWDATA = txd_a[gnt_q];
        end
        S_POLL:  apb.M_PADDR = ADDR_STATUS;
        S_RX:    apb.M_PADDR = ADDR_RXDATA;
        S_DESEL: begin
          apb.M_PADDR = ADDR_SSEL; apb.M_PWRITE = 1'b1; apb.M_PWDATA = 8'h00;
        end
        default: apb.M_PADDR = '0;
      endcase
    end
  end

  assign rx_valid = rxv_q;
  assign rx_data  = rxd_q;
  assign done     = (state_q == S_DONE) ? gnt_oh : 2'b00;
  assign err      = done & {2{err_q}};

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Bench for spi_apb_sequencer: loopback CoreSPI slave model, requester model
// and a transaction-level expectation of the APB write stream per request.
module tb_spi_apb_sequencer;
  localparam logic [6:0] A_CTRL1 = 7'h00, A_RX = 7'h08, A_TX = 7'h0C;
  localparam logic [6:0] A_ST = 7'h20, A_SS = 7'h24, A_TXL = 7'h28;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [5:0]  req_ssel = '0;
  logic [15:0] req_len = '0;
  logic [15:0] tx_data;
  logic [1:0]  tx_ack, rx_valid, done, err;
  logic [7:0]  rx_data;

  spi_apb_sequencer_if apb();

  spi_apb_sequencer #(.POLL_LIMIT(16'd4)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .req_valid(req_valid), .req_ssel(req_ssel),
    .req_len(req_len), .tx_data(tx_data), .tx_ack(tx_ack), .rx_data(rx_data),
    .rx_valid(rx_valid), .done(done), .err(err), .apb(apb)
  );

  always #5 PCLK = ~PCLK;

  int vectors = 0, miscompares = 0;

  logic [7:0]  tx_bytes [2][256];
  int          tx_idx [2];
  logic        pend_adv [2];
  logic        hold_mode = 1'b0, stuck_empty = 1'b0, err_on_tx = 1'b0;
  int          wait_n = 0;
  logic [7:0]  rxq [$];
  logic [15:0] wlog [$];
  logic [15:0] exp_w [$];
  logic [8:0]  rxlog [$];
  logic [1:0]  donelog [$];
  int          ack_cnt [2];
  int          status_reads, rx_reads, psel_cycles, tx_en_run, proto_err, lat_err;
  int          wcnt, en_run, tick_no, rx_tick, desel_tick, done_tick;
  logic        prev_ready;
  logic [15:0] setup_snap;

  assign tx_data = {tx_bytes[1][tx_idx[1]], tx_bytes[0][tx_idx[0]]};

  // One clock of environment: slave response, requester bookkeeping, logging.
  task automatic tick();
    @(negedge PCLK);
    tick_no++;
    for (int r = 0; r < 2; r++) if (pend_adv[r]) begin tx_idx[r]++; pend_adv[r] = 1'b0; end
    apb.M_PREADY = 1'b0;
    apb.M_PSLVERR = 1'b0;
    if (!PRESETN) begin
      wcnt = 0; prev_ready = 1'b0;
    end else if (apb.M_PSEL) begin
      psel_cycles++;
      if (prev_ready) proto_err++;
      if (!apb.M_PENABLE) begin
        setup_snap = {apb.M_PWRITE, apb.M_PADDR, apb.M_PWDATA};
        wcnt = 0; en_run = 0;
      end else begin
        en_run++;
        if ({apb.M_PWRITE, apb.M_PADDR, apb.M_PWDATA} !== setup_snap) proto_err++;
        if (wcnt < wait_n) wcnt++;
        else begin
          apb.M_PREADY = 1'b1;
          if (apb.M_PWRITE) begin
            wlog.push_back({1'b0, apb.M_PADDR, apb.M_PWDATA});
            if (apb.M_PADDR == A_TX || apb.M_PADDR == A_TXL) begin
              tx_en_run = en_run;
              if (err_on_tx && apb.M_PADDR == A_TX) apb.M_PSLVERR = 1'b1;
              else rxq.push_back(apb.M_PWDATA);
            end
            if (apb.M_PADDR == A_SS && apb.M_PWDATA == 8'h00) desel_tick = tick_no;
          end else if (apb.M_PADDR == A_ST) begin
            status_reads++;
            apb.M_PRDATA = (stuck_empty || rxq.size() == 0) ? 8'h04 : 8'h00;
          end else if (apb.M_PADDR == A_RX) begin
            rx_reads++;
            rx_tick = tick_no;
            apb.M_PRDATA = (rxq.size() != 0) ? rxq.pop_front() : 8'hEE;
          end
        end
      end
    end
    prev_ready = apb.M_PREADY;
    #1;
    for (int r = 0; r < 2; r++) if (tx_ack[r]) begin ack_cnt[r]++; pend_adv[r] = 1'b1; end
    if (rx_valid != 2'b00) begin
      rxlog.push_back({rx_valid[1], rx_data});
      if (tick_no != rx_tick + 1 || rx_valid == 2'b11) lat_err++;
    end
    for (int r = 0; r < 2; r++) if (done[r]) begin
      donelog.push_back({1'(r), err[r]});
      done_tick = tick_no;
      if (hold_mode) begin tx_idx[r] = 0; pend_adv[r] = 1'b0; end
      else req_valid[r] = 1'b0;
    end
  endtask

  task automatic clear_logs();
    wlog.delete(); rxlog.delete(); donelog.delete(); rxq.delete();
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    status_reads = 0; rx_reads = 0; psel_cycles = 0; tx_en_run = 0;
    proto_err = 0; lat_err = 0; desel_tick = -100; done_tick = -100;
  endtask

  task automatic start_req(input int r, input logic [2:0] ss, input int len);
    req_ssel[3*r +: 3] = ss;
    req_len[8*r +: 8]  = 8'(len);
    tx_idx[r] = 0; pend_adv[r] = 1'b0;
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_done(input int n, output bit ok);
    int budget = 3000;
    while (donelog.size() < n && budget > 0) begin tick(); budget--; end
    ok = (donelog.size() >= n);
  endtask

  task automatic test_reset();
    bit ok;
    clear_logs();
    tick();
    vectors++;
    if ({apb.M_PSEL, apb.M_PENABLE, apb.M_PWRITE, apb.M_PADDR, apb.M_PWDATA} !== 18'h0) begin
      miscompares++; $display("FAIL reset_apb: got %h want 0",
        {apb.M_PSEL, apb.M_PENABLE, apb.M_PWRITE, apb.M_PADDR, apb.M_PWDATA});
    end
    vectors++;
    if ({tx_ack, rx_valid, done, err, rx_data} !== 16'h0) begin
      miscompares++; $display("FAIL reset_out: got %h want 0", {tx_ack, rx_valid, done, err, rx_data});
    end
    PRESETN = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    ok = (wlog.size() == 1);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL init_ops: got %0d ops want 1", wlog.size()); end
    else begin
      vectors++;
      if (wlog[0] !== {1'b0, A_CTRL1, 8'h03}) begin
        miscompares++; $display("FAIL init_ctrl1: got %h want %h", wlog[0], {1'b0, A_CTRL1, 8'h03});
      end
    end
    vectors++;
    if ({apb.M_PSEL, tx_ack, rx_valid, done, err} !== 9'h0) begin
      miscompares++; $display("FAIL idle_out: got %h want 0", {apb.M_PSEL, tx_ack, rx_valid, done, err});
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    hold_mode = 1'b1;
    tx_bytes[0][0] = 8'h11; tx_bytes[1][0] = 8'h22;
    req_ssel = {3'd2, 3'd1};
    req_len  = {8'd1, 8'd1};
    tx_idx[0] = 0; tx_idx[1] = 0;
    req_valid = 2'b11;
    wait_done(4, ok);
    hold_mode = 1'b0;
    req_valid = 2'b00;
    tick(); tick();
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rr_timeout: got %0d dones want 4", donelog.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++;
      if (donelog[i] !== {1'(i % 2), 1'b0}) begin
        miscompares++; $display("FAIL rr_grant%0d: got %b want %b", i, donelog[i], {1'(i % 2), 1'b0});
      end
    end
  endtask

  task automatic test_transfers();
    bit ok;
    int r, len;
    logic [2:0] ss;
    for (int k = 0; k < 8; k++) begin
      clear_logs();
      if (k == 0) begin
        r = 0; ss = 3'd3; len = 2; wait_n = 0;
        tx_bytes[0][0] = 8'hA5; tx_bytes[0][1] = 8'h5A;
      end else begin
        r = int'($urandom_range(1, 0)); ss = 3'($urandom_range(7, 0));
        len = int'($urandom_range(6, 1)); wait_n = int'($urandom_range(2, 0));
        for (int i = 0; i < len; i++) tx_bytes[r][i] = 8'($urandom);
      end
      // Expected APB writes: select, one TX write per byte (last to TXLAST), deselect.
      exp_w.delete();
      exp_w.push_back({1'b0, A_SS, 8'b1 << ss});
      for (int i = 0; i < len; i++) exp_w.push_back({1'b0, (i == len - 1) ? A_TXL : A_TX, tx_bytes[r][i]});
      exp_w.push_back({1'b0, A_SS, 8'h00});
      start_req(r, ss, len);
      wait_done(1, ok);
      tick(); tick();
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL xfer%0d_timeout: got no done want done", k); continue; end
      vectors++;
      if (wlog.size() != exp_w.size()) begin
        miscompares++; $display("FAIL xfer%0d_nwr: got %0d want %0d", k, wlog.size(), exp_w.size());
      end else for (int i = 0; i < exp_w.size(); i++) begin
        vectors++;
        if (wlog[i] !== exp_w[i]) begin
          miscompares++; $display("FAIL xfer%0d_wr%0d: got %h want %h", k, i, wlog[i], exp_w[i]);
        end
      end
      vectors++;
      if (rxlog.size() != len) begin
        miscompares++; $display("FAIL xfer%0d_nrx: got %0d want %0d", k, rxlog.size(), len);
      end else for (int i = 0; i < len; i++) begin
        vectors++;
        if (rxlog[i] !== {1'(r), tx_bytes[r][i]}) begin
          miscompares++; $display("FAIL xfer%0d_rx%0d: got %h want %h", k, i, rxlog[i], {1'(r), tx_bytes[r][i]});
        end
      end
      vectors++;
      if (donelog[0] !== {1'(r), 1'b0}) begin
        miscompares++; $display("FAIL xfer%0d_done: got %b want %b", k, donelog[0], {1'(r), 1'b0});
      end
      vectors++;
      if (ack_cnt[r] != len || ack_cnt[1-r] != 0) begin
        miscompares++; $display("FAIL xfer%0d_ack: got %0d/%0d want %0d/0", k, ack_cnt[r], ack_cnt[1-r], len);
      end
      vectors++;
      if (status_reads != len || rx_reads != len) begin
        miscompares++; $display("FAIL xfer%0d_reads: got %0d/%0d want %0d", k, status_reads, rx_reads, len);
      end
      vectors++;
      if (proto_err != 0 || lat_err != 0 || done_tick != desel_tick + 1) begin
        miscompares++; $display("FAIL xfer%0d_timing: got proto=%0d lat=%0d dlat=%0d want 0 0 1",
          k, proto_err, lat_err, done_tick - desel_tick);
      end
    end
    wait_n = 0;
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    stuck_empty = 1'b1;
    tx_bytes[0][0] = 8'h3C; tx_bytes[0][1] = 8'h77; tx_bytes[0][2] = 8'h99;
    start_req(0, 3'd1, 3);
    wait_done(1, ok);
    tick(); tick();
    stuck_empty = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL to_timeout: got no done want done"); end
    else begin
      vectors++;
      if (status_reads != 4) begin miscompares++; $display("FAIL to_polls: got %0d want 4", status_reads); end
      vectors++;
      if (wlog.size() != 3 || wlog[0] !== {1'b0, A_SS, 8'h02} || wlog[1] !== {1'b0, A_TX, 8'h3C} ||
          wlog[2] !== {1'b0, A_SS, 8'h00}) begin
        miscompares++; $display("FAIL to_writes: got %0d ops want SSEL,TX 3C,SSEL 00", wlog.size());
      end
      vectors++;
      if (donelog[0] !== 2'b01 || ack_cnt[0] != 1 || rxlog.size() != 0 || rx_reads != 0) begin
        miscompares++; $display("FAIL to_done: got %b ack=%0d rx=%0d want 01 ack=1 rx=0",
          donelog[0], ack_cnt[0], rxlog.size());
      end
    end
  endtask

  task automatic test_pslverr();
    bit ok;
    clear_logs();
    err_on_tx = 1'b1; wait_n = 2;
    tx_bytes[1][0] = 8'hC3; tx_bytes[1][1] = 8'h4B;
    start_req(1, 3'd5, 2);
    wait_done(1, ok);
    tick(); tick();
    err_on_tx = 1'b0; wait_n = 0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL se_timeout: got no done want done"); end
    else begin
      vectors++;
      if (tx_en_run != 3) begin miscompares++; $display("FAIL se_penable: got %0d want 3", tx_en_run); end
      vectors++;
      if (wlog.size() != 3 || wlog[0] !== {1'b0, A_SS, 8'h20} || wlog[1] !== {1'b0, A_TX, 8'hC3} ||
          wlog[2] !== {1'b0, A_SS, 8'h00}) begin
        miscompares++; $display("FAIL se_writes: got %0d ops want SSEL 20,TX C3,SSEL 00", wlog.size());
      end
      vectors++;
      if (donelog[0] !== 2'b11 || ack_cnt[1] != 0 || status_reads != 0) begin
        miscompares++; $display("FAIL se_done: got %b ack=%0d st=%0d want 11 ack=0 st=0",
          donelog[0], ack_cnt[1], status_reads);
      end
    end
  endtask

  task automatic test_zero_len();
    int t = 0;
    clear_logs();
    start_req(1, 3'd4, 0);
    while (donelog.size() == 0 && t < 20) begin tick(); t++; end
    tick(); tick();
    vectors++;
    if (t != 1) begin miscompares++; $display("FAIL zl_latency: got %0d want 1", t); end
    vectors++;
    if (donelog.size() != 1 || donelog[0] !== 2'b11) begin
      miscompares++; $display("FAIL zl_done: got %0d dones want one 11", donelog.size());
    end
    vectors++;
    if (psel_cycles != 0) begin miscompares++; $display("FAIL zl_apb: got %0d psel cycles want 0", psel_cycles); end
  endtask

  task automatic test_reset_mid_poll();
    int t = 0;
    clear_logs();
    stuck_empty = 1'b1;
    tx_bytes[0][0] = 8'h81;
    start_req(0, 3'd0, 1);
    while (!(apb.M_PSEL && apb.M_PADDR == A_ST) && t < 100) begin tick(); t++; end
    vectors++;
    if (t >= 100) begin miscompares++; $display("FAIL rp_poll: got no STATUS read want one"); end
    #2;
    PRESETN = 1'b0;
    #1;
    vectors++;
    if ({apb.M_PSEL, apb.M_PENABLE} !== 2'b00) begin
      miscompares++; $display("FAIL rp_abort: got %b want 00", {apb.M_PSEL, apb.M_PENABLE});
    end
    req_valid = 2'b00; stuck_empty = 1'b0;
    tick(); tick();
    clear_logs();
    PRESETN = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (wlog.size() != 1 || wlog[0] !== {1'b0, A_CTRL1, 8'h03} || donelog.size() != 0) begin
      miscompares++; $display("FAIL rp_reinit: got %0d ops %0d dones want CTRL1 only", wlog.size(), donelog.size());
    end
  endtask

  initial begin
    apb.M_PRDATA = '0; apb.M_PREADY = 1'b0; apb.M_PSLVERR = 1'b0;
    tick_no = 0; rx_tick = -100; prev_ready = 1'b0; wcnt = 0; en_run = 0; setup_snap = '0;
    tx_idx[0] = 0; tx_idx[1] = 0; pend_adv[0] = 1'b0; pend_adv[1] = 1'b0;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 256; i++) tx_bytes[r][i] = '0;
    test_reset();
    test_back_to_back();
    test_transfers();
    test_timeout();
    test_pslverr();
    test_zero_len();
    test_reset_mid_poll();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
